ysyx_23060061_lsu: RTL

Multi-cycle load/store unit for the next-generation NPC core. It replaces the same-cycle DPI memory access with a valid/ready request/response handshake toward a memory bus. The unit handles lane alignment, byte-strobe generation and load sign/zero extension. It also detects misaligned accesses, propagates bus errors, and times out on hung transactions. It sits between the EX stage (request side) and the WB mux (response side).

---
 rtl/ysyx_23060061_lsu.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_23060061_lsu.sv
// Multi-cycle load/store unit: turns one core access into a valid/ready bus
// transaction. It aligns store data into byte lanes and generates byte strobes.
// Load data is extracted from its lane and sign/zero extended. Misaligned
// accesses, bus errors and hung transactions are reported through resp_err.
module ysyx_23060061_lsu #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic [1:0]          resp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_rsp_valid,
    input  logic                mem_rsp_err,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int CNT_W  = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_MIS = 2'b01;
    localparam logic [1:0] ERR_BUS = 2'b10;
    localparam logic [1:0] ERR_TMO = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                wen_q, wen_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          err_q, err_d;
    logic [OFF_W-1:0]    off_q;

    assign off_q = addr_q[OFF_W-1:0];

    // An access is misaligned when the address is not a multiple of its size;
    // a dword on a 32-bit bus can never be served.
    function automatic logic is_misaligned(input logic [ADDR_W-1:0] a, input logic [1:0] sz);
        logic m;
        case (sz)
            2'b00:   m = 1'b0;
            2'b01:   m = a[0];
            2'b10:   m = |a[1:0];
            default: m = (DATA_W == 32) ? 1'b1 : |a[2:0];
        endcase
        return m;
    endfunction

    // Byte-enable pattern of an access before it is moved to its lane.
    function automatic logic [STRB_W-1:0] lane_mask(input logic [1:0] sz);
        logic [STRB_W-1:0] m;
        case (sz)
            2'b00:   m = STRB_W'(1);
            2'b01:   m = STRB_W'(3);
            2'b10:   m = STRB_W'(15);
            default: m = '1;
        endcase
        return m;
    endfunction

    // Pulls the addressed field down to bit 0 and extends it. A full-width
    // field has an all-ones mask, so the sign fill vanishes on its own.
    function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] raw,
                                                      input logic [OFF_W-1:0]  off,
                                                      input logic [1:0]        sz,
                                                      input logic              uns);
        logic [DATA_W-1:0] sh;
        logic [DATA_W-1:0] m;
        logic              sb;
        sh = raw >> {off, 3'b000};
        case (sz)
            2'b00:   begin m = DATA_W'(8'hFF);         sb = sh[7];        end
            2'b01:   begin m = DATA_W'(16'hFFFF);      sb = sh[15];       end
            2'b10:   begin m = DATA_W'(32'hFFFF_FFFF); sb = sh[31];       end
            default: begin m = '1;                     sb = sh[DATA_W-1]; end
        endcase
        return (sh & m) | ((!uns && sb) ? ~m : '0);
    endfunction

    // Control state: reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Access fields and captured response; only meaningful while a transaction is live.
    always_ff @(posedge clk) begin
        wen_q   <= wen_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        size_q  <= size_d;
        uns_q   <= uns_d;
        rdata_q <= rdata_d;
        err_q   <= err_d;
    end

    // Next-state logic: accept, issue to the bus, wait for a response or timeout, hand back.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wen_d   = req_wen;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    if (is_misaligned(req_addr, req_size)) begin
                        err_d   = ERR_MIS;
                        rdata_d = '0;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mem_rsp_valid) begin
                    state_d = S_RESP;
                    if (mem_rsp_err) begin
                        err_d   = ERR_BUS;
                        rdata_d = '0;
                    end else begin
                        err_d   = ERR_OK;
                        rdata_d = wen_q ? '0 : load_extend(mem_rdata, off_q, size_q, uns_q);
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = S_RESP;
                    err_d   = ERR_TMO;
                    rdata_d = '0;
                end
            end
            S_RESP: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode from the state; everything is forced low while reset is held.
    always_comb begin
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_rdata    = '0;
        resp_err      = ERR_OK;
        mem_req_valid = 1'b0;
        mem_wen       = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_wstrb     = '0;
        if (!rst) begin
            case (state_q)
                S_IDLE: req_ready = 1'b1;
                S_REQ: begin
                    mem_req_valid = 1'b1;
                    mem_wen       = wen_q;
                    mem_addr      = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    if (wen_q) begin
                        mem_wdata = wdata_q << {off_q, 3'b000};
                        mem_wstrb = lane_mask(size_q) << off_q;
                    end
                end
                S_RESP: begin
                    resp_valid = 1'b1;
                    resp_rdata = rdata_q;
                    resp_err   = err_q;
                end
                default: ;
            endcase
        end
    end

endmodule
